// File: rtl/fft_neg_arbiter.sv
// Round-robin arbiter sharing one two's-complement negation unit between NUM_REQ requesters.
// Optional FFT_NEG_SAT_EN: negating the most-negative operand saturates to the maximum positive value.
//
// state | meaning
// EMPTY | result register holds no valid data
// FULL  | result register holds a result waiting for out_ready_i
module fft_neg_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_neg_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [ID_WIDTH-1:0]           out_id_o,
  output logic                          out_ovf_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef FFT_NEG_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   ptr, ptr_next, grant_idx;
  logic                  found, can_accept, transfer;
  logic [DATA_WIDTH-1:0] ops [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_sel, neg_val, result;
  logic                  neg_sel, ovf_next;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign ops[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin : search
    logic [ID_WIDTH-1:0] cand;
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign can_accept  = (state == EMPTY) || out_ready_i;
  assign transfer    = found && can_accept && !rst_i;
  assign out_valid_o = (state == FULL);

  always_comb begin
    req_ready_o = '0;
    if (transfer) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    op_sel   = ops[grant_idx];
    neg_sel  = req_neg_i[grant_idx];
    neg_val  = ~op_sel + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    ovf_next = neg_sel && (op_sel == MOST_NEG);
`ifdef FFT_NEG_SAT_EN
    result   = ovf_next ? MAX_POS : (neg_sel ? neg_val : op_sel);
`else
    result   = neg_sel ? neg_val : op_sel;
`endif
  end

  always_comb begin
    ptr_next = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (transfer) state_next = FULL;
      FULL:    if (out_ready_i && !transfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= EMPTY;
      ptr        <= '0;
      out_data_o <= '0;
      out_id_o   <= '0;
      out_ovf_o  <= 1'b0;
    end else begin
      state <= state_next;
      if (transfer) begin
        out_data_o <= result;
        out_id_o   <= grant_idx;
        out_ovf_o  <= ovf_next;
        ptr        <= ptr_next;
      end
    end
  end

endmodule
